// File: rtl/banked_memory.sv
// ---------------------------------------------------------------------------
// banked_memory
//   Two-port, multi-bank word memory with byte enables and valid/ready
//   request handshakes. Word addresses are low-order interleaved across
//   NUM_BANKS single-port banks. Requests to different banks are served in
//   the same cycle; same-bank conflicts are resolved round-robin. Every
//   accepted request (read or write) returns exactly one response on its own
//   port, READ_LAT cycles after acceptance, carrying the write-first word.
//
// Parameters
//   DATA_W    word width in bits (multiple of 8)
//   ADDR_W    word address width; depth = 2**ADDR_W words
//   NUM_BANKS bank count (power of 2, >= 2)
//   READ_LAT  response latency in cycles (1..4)
//
// Ports (x = a or b, two identical request/response ports)
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   x_req_valid  request present
//   x_req_ready  request accepted this cycle when valid && ready
//   x_we         1 = write, 0 = read
//   x_addr       word address
//   x_wdata      write data
//   x_be         byte enables, bit i covers wdata[8i+7:8i]
//   x_rsp_valid  one-cycle response pulse
//   x_rdata      response word, holds while x_rsp_valid = 0
// ---------------------------------------------------------------------------
module banked_memory #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int NUM_BANKS = 4,
    parameter int READ_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic                  a_we,
    input  logic [ADDR_W-1:0]     a_addr,
    input  logic [DATA_W-1:0]     a_wdata,
    input  logic [DATA_W/8-1:0]   a_be,
    output logic                  a_rsp_valid,
    output logic [DATA_W-1:0]     a_rdata,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_we,
    input  logic [ADDR_W-1:0]     b_addr,
    input  logic [DATA_W-1:0]     b_wdata,
    input  logic [DATA_W/8-1:0]   b_be,
    output logic                  b_rsp_valid,
    output logic [DATA_W-1:0]     b_rdata
);

    localparam int BE_W   = DATA_W / 8;
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = ADDR_W - BANK_W;
    localparam int ROWS   = 1 << ROW_W;

    // ------------------------------------------------------------------
    // Address split and arbitration
    // ------------------------------------------------------------------
    logic [BANK_W-1:0] a_bank, b_bank;
    logic [ROW_W-1:0]  a_row,  b_row;
    logic              conflict;
    logic              prio;        // 0 = A wins a conflict, 1 = B wins
    logic              a_acc, b_acc;

    assign a_bank = a_addr[BANK_W-1:0];
    assign b_bank = b_addr[BANK_W-1:0];
    assign a_row  = a_addr[ADDR_W-1:BANK_W];
    assign b_row  = b_addr[ADDR_W-1:BANK_W];

    assign conflict = a_req_valid && b_req_valid && (a_bank == b_bank);

    // Ready never looks at ready of the other port, only at valids and prio.
    assign a_req_ready = !rst && (!conflict || !prio);
    assign b_req_ready = !rst && (!conflict ||  prio);

    assign a_acc = a_req_valid && a_req_ready;
    assign b_acc = b_req_valid && b_req_ready;

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (conflict) begin
            // The winner was the port selected by prio; favour the loser next.
            prio <= ~prio;
        end
    end

    // ------------------------------------------------------------------
    // Banks: each bank serves at most one port per cycle. The combinational
    // merged word is the write-first value returned to the accepting port.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] bank_merged [NUM_BANKS];

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        localparam logic [BANK_W-1:0] IDX = BANK_W'(g);

        logic [DATA_W-1:0] mem [ROWS];
        logic              use_b;
        logic              en;
        logic              we;
        logic [ROW_W-1:0]  row;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] rd;
        logic [DATA_W-1:0] merged;

        // NOTE: every signal written here gets a value on every path, so no
        // latch is inferred.
        always_comb begin
            use_b = b_acc && (b_bank == IDX);
            en    = use_b || (a_acc && (a_bank == IDX));
            we    = use_b ? b_we    : a_we;
            row   = use_b ? b_row   : a_row;
            wdata = use_b ? b_wdata : a_wdata;
            mask  = '0;
            for (int i = 0; i < BE_W; i++) begin
                mask[8*i +: 8] = {8{use_b ? b_be[i] : a_be[i]}};
            end
            rd     = mem[row];
            merged = we ? ((rd & ~mask) | (wdata & mask)) : rd;
        end

        assign bank_merged[g] = merged;

        // NOTE: storage array has no reset; contents are undefined until
        // written, which keeps it mappable onto plain RAM.
        always_ff @(posedge clk) begin
            if (en && we) begin
                mem[row] <= merged;
            end
        end
    end

    // ------------------------------------------------------------------
    // Response pipelines. Stage 0 captures the bank result at the acceptance
    // edge; later stages are pure delay. Data only advances alongside a valid
    // bit so the output word holds between responses.
    // ------------------------------------------------------------------
    logic [READ_LAT-1:0] a_pv, b_pv;
    logic [DATA_W-1:0]   a_pd [READ_LAT];
    logic [DATA_W-1:0]   b_pd [READ_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            a_pv <= '0;
            b_pv <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                a_pd[i] <= '0;
                b_pd[i] <= '0;
            end
        end else begin
            a_pv[0] <= a_acc;
            b_pv[0] <= b_acc;
            if (a_acc) a_pd[0] <= bank_merged[a_bank];
            if (b_acc) b_pd[0] <= bank_merged[b_bank];
            for (int i = 1; i < READ_LAT; i++) begin
                a_pv[i] <= a_pv[i-1];
                b_pv[i] <= b_pv[i-1];
                if (a_pv[i-1]) a_pd[i] <= a_pd[i-1];
                if (b_pv[i-1]) b_pd[i] <= b_pd[i-1];
            end
        end
    end

    assign a_rsp_valid = a_pv[READ_LAT-1];
    assign b_rsp_valid = b_pv[READ_LAT-1];
    assign a_rdata     = a_pd[READ_LAT-1];
    assign b_rdata     = b_pd[READ_LAT-1];

endmodule

// File: tb/tb_banked_memory.sv
// ---------------------------------------------------------------------------
// tb_banked_memory
//   Directed bench for banked_memory. Instance dut uses READ_LAT=1, instance
//   dut3 uses READ_LAT=3; both share clk and rst. Inputs change 1 ns after
//   the rising edge and outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_banked_memory;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // READ_LAT = 1 instance
    logic        a_req_valid, a_req_ready, a_we, a_rsp_valid;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic [3:0]  a_be;
    logic        b_req_valid, b_req_ready, b_we, b_rsp_valid;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic [3:0]  b_be;

    // READ_LAT = 3 instance
    logic        t_a_req_valid, t_a_req_ready, t_a_we, t_a_rsp_valid;
    logic [9:0]  t_a_addr;
    logic [31:0] t_a_wdata, t_a_rdata;
    logic [3:0]  t_a_be;
    logic        t_b_req_valid, t_b_req_ready, t_b_we, t_b_rsp_valid;
    logic [9:0]  t_b_addr;
    logic [31:0] t_b_wdata, t_b_rdata;
    logic [3:0]  t_b_be;

    banked_memory #(.DATA_W(32), .ADDR_W(10), .NUM_BANKS(4), .READ_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_we(a_we),
        .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
        .a_rsp_valid(a_rsp_valid), .a_rdata(a_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_we(b_we),
        .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
        .b_rsp_valid(b_rsp_valid), .b_rdata(b_rdata)
    );

    banked_memory #(.DATA_W(32), .ADDR_W(10), .NUM_BANKS(4), .READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst),
        .a_req_valid(t_a_req_valid), .a_req_ready(t_a_req_ready), .a_we(t_a_we),
        .a_addr(t_a_addr), .a_wdata(t_a_wdata), .a_be(t_a_be),
        .a_rsp_valid(t_a_rsp_valid), .a_rdata(t_a_rdata),
        .b_req_valid(t_b_req_valid), .b_req_ready(t_b_req_ready), .b_we(t_b_we),
        .b_addr(t_b_addr), .b_wdata(t_b_wdata), .b_be(t_b_be),
        .b_rsp_valid(t_b_rsp_valid), .b_rdata(t_b_rdata)
    );

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic we, input logic [9:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
        a_req_valid = v; a_we = we; a_addr = addr; a_wdata = wd; a_be = be;
    endtask

    task automatic drive_b(input logic v, input logic we, input logic [9:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
        b_req_valid = v; b_we = we; b_addr = addr; b_wdata = wd; b_be = be;
    endtask

    task automatic drive_ta(input logic v, input logic we, input logic [9:0] addr,
                            input logic [31:0] wd, input logic [3:0] be);
        t_a_req_valid = v; t_a_we = we; t_a_addr = addr; t_a_wdata = wd; t_a_be = be;
    endtask

    task automatic drive_tb(input logic v, input logic we, input logic [9:0] addr,
                            input logic [31:0] wd, input logic [3:0] be);
        t_b_req_valid = v; t_b_we = we; t_b_addr = addr; t_b_wdata = wd; t_b_be = be;
    endtask

    task automatic idle_all();
        drive_a(0, 0, '0, '0, '0);
        drive_b(0, 0, '0, '0, '0);
        drive_ta(0, 0, '0, '0, '0);
        drive_tb(0, 0, '0, '0, '0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive_a(1, 1, 10'd7, 32'h5555_5555, 4'hF);
        drive_b(1, 0, 10'd3, 32'h0, 4'h0);
        repeat (3) step();
        if (a_req_ready !== 1'b0) begin $display("FAIL rst_a_ready: got %b want 0", a_req_ready); failures++; end checks++;
        if (b_req_ready !== 1'b0) begin $display("FAIL rst_b_ready: got %b want 0", b_req_ready); failures++; end checks++;
        if (a_rsp_valid !== 1'b0) begin $display("FAIL rst_a_rsp_valid: got %b want 0", a_rsp_valid); failures++; end checks++;
        if (b_rsp_valid !== 1'b0) begin $display("FAIL rst_b_rsp_valid: got %b want 0", b_rsp_valid); failures++; end checks++;
        if (a_rdata !== 32'h0) begin $display("FAIL rst_a_rdata: got %h want 0", a_rdata); failures++; end checks++;
        if (dut.prio !== 1'b0) begin $display("FAIL rst_prio: got %b want 0", dut.prio); failures++; end checks++;
        if (t_a_rsp_valid !== 1'b0) begin $display("FAIL rst_l3_rsp_valid: got %b want 0", t_a_rsp_valid); failures++; end checks++;
        idle_all();
        rst = 1'b0;
        step();
    endtask

    task automatic test_write_read();
        drive_a(1, 1, 10'd5, 32'hDEAD_BEEF, 4'hF);
        #1;
        if (a_req_ready !== 1'b1) begin $display("FAIL wr_a_ready: got %b want 1", a_req_ready); failures++; end checks++;
        step();
        if (a_rsp_valid !== 1'b1) begin $display("FAIL wr_a_rsp_valid: got %b want 1", a_rsp_valid); failures++; end checks++;
        if (a_rdata !== 32'hDEAD_BEEF) begin $display("FAIL wr_a_rdata: got %h want deadbeef", a_rdata); failures++; end checks++;
        drive_a(0, 0, '0, '0, '0);
        drive_b(1, 0, 10'd5, 32'h0, 4'h0);
        step();
        if (b_rsp_valid !== 1'b1) begin $display("FAIL rd_b_rsp_valid: got %b want 1", b_rsp_valid); failures++; end checks++;
        if (b_rdata !== 32'hDEAD_BEEF) begin $display("FAIL rd_b_rdata: got %h want deadbeef", b_rdata); failures++; end checks++;
        if (a_rsp_valid !== 1'b0) begin $display("FAIL rd_a_quiet: got %b want 0", a_rsp_valid); failures++; end checks++;
        if (a_rdata !== 32'hDEAD_BEEF) begin $display("FAIL a_rdata_hold: got %h want deadbeef", a_rdata); failures++; end checks++;
        drive_b(0, 0, '0, '0, '0);
        step();
        if (b_rsp_valid !== 1'b0) begin $display("FAIL b_rsp_pulse: got %b want 0", b_rsp_valid); failures++; end checks++;
        if (b_rdata !== 32'hDEAD_BEEF) begin $display("FAIL b_rdata_hold: got %h want deadbeef", b_rdata); failures++; end checks++;
    endtask

    task automatic test_byte_enable();
        drive_a(1, 1, 10'd9, 32'h1122_3344, 4'hF);
        step();
        drive_a(1, 1, 10'd9, 32'h55AA_6677, 4'b0010);
        step();
        if (a_rsp_valid !== 1'b1) begin $display("FAIL be_rsp_valid: got %b want 1", a_rsp_valid); failures++; end checks++;
        if (a_rdata !== 32'h1122_6644) begin $display("FAIL be_write_rsp: got %h want 11226644", a_rdata); failures++; end checks++;
        drive_a(1, 0, 10'd9, 32'h0, 4'h0);
        step();
        if (a_rdata !== 32'h1122_6644) begin $display("FAIL be_readback: got %h want 11226644", a_rdata); failures++; end checks++;
        drive_a(0, 0, '0, '0, '0);
        step();
    endtask

    task automatic test_conflict();
        drive_a(1, 1, 10'd4, 32'h4444_4444, 4'hF);
        step();
        drive_a(1, 1, 10'd8, 32'h8888_8888, 4'hF);
        step();
        drive_a(0, 0, '0, '0, '0);
        step();
        if (dut.prio !== 1'b0) begin $display("FAIL cf_prio_start: got %b want 0", dut.prio); failures++; end checks++;
        drive_a(1, 0, 10'd4, 32'h0, 4'h0);
        drive_b(1, 0, 10'd8, 32'h0, 4'h0);
        #1;
        if (a_req_ready !== 1'b1) begin $display("FAIL cf1_a_ready: got %b want 1", a_req_ready); failures++; end checks++;
        if (b_req_ready !== 1'b0) begin $display("FAIL cf1_b_ready: got %b want 0", b_req_ready); failures++; end checks++;
        step();
        if (dut.prio !== 1'b1) begin $display("FAIL cf1_prio: got %b want 1", dut.prio); failures++; end checks++;
        if (a_rsp_valid !== 1'b1) begin $display("FAIL cf1_a_rsp: got %b want 1", a_rsp_valid); failures++; end checks++;
        if (b_rsp_valid !== 1'b0) begin $display("FAIL cf1_b_rsp: got %b want 0", b_rsp_valid); failures++; end checks++;
        if (a_rdata !== 32'h4444_4444) begin $display("FAIL cf1_a_rdata: got %h want 44444444", a_rdata); failures++; end checks++;
        #1;
        if (a_req_ready !== 1'b0) begin $display("FAIL cf2_a_ready: got %b want 0", a_req_ready); failures++; end checks++;
        if (b_req_ready !== 1'b1) begin $display("FAIL cf2_b_ready: got %b want 1", b_req_ready); failures++; end checks++;
        step();
        if (dut.prio !== 1'b0) begin $display("FAIL cf2_prio: got %b want 0", dut.prio); failures++; end checks++;
        if (b_rsp_valid !== 1'b1) begin $display("FAIL cf2_b_rsp: got %b want 1", b_rsp_valid); failures++; end checks++;
        if (a_rsp_valid !== 1'b0) begin $display("FAIL cf2_a_rsp: got %b want 0", a_rsp_valid); failures++; end checks++;
        if (b_rdata !== 32'h8888_8888) begin $display("FAIL cf2_b_rdata: got %h want 88888888", b_rdata); failures++; end checks++;
        idle_all();
        step();
    endtask

    task automatic test_parallel();
        drive_a(1, 1, 10'd1, 32'hA1A1_A1A1, 4'hF);
        drive_b(1, 1, 10'd2, 32'hB2B2_B2B2, 4'hF);
        #1;
        if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
            $display("FAIL par_ready: got %b%b want 11", a_req_ready, b_req_ready); failures++;
        end checks++;
        step();
        if (a_rsp_valid !== 1'b1 || b_rsp_valid !== 1'b1) begin
            $display("FAIL par_rsp_valid: got %b%b want 11", a_rsp_valid, b_rsp_valid); failures++;
        end checks++;
        if (a_rdata !== 32'hA1A1_A1A1) begin $display("FAIL par_a_rdata: got %h want a1a1a1a1", a_rdata); failures++; end checks++;
        if (b_rdata !== 32'hB2B2_B2B2) begin $display("FAIL par_b_rdata: got %h want b2b2b2b2", b_rdata); failures++; end checks++;
        if (dut.prio !== 1'b0) begin $display("FAIL par_prio: got %b want 0", dut.prio); failures++; end checks++;
        // Identical addresses always conflict.
        drive_a(1, 1, 10'd6, 32'h0000_AAAA, 4'hF);
        drive_b(1, 1, 10'd6, 32'hBBBB_0000, 4'hF);
        #1;
        if (a_req_ready !== 1'b1 || b_req_ready !== 1'b0) begin
            $display("FAIL same_addr_ready: got %b%b want 10", a_req_ready, b_req_ready); failures++;
        end checks++;
        step();
        if (a_rdata !== 32'h0000_AAAA) begin $display("FAIL same_addr_a_rdata: got %h want 0000aaaa", a_rdata); failures++; end checks++;
        drive_a(0, 0, '0, '0, '0);
        #1;
        if (b_req_ready !== 1'b1) begin $display("FAIL same_addr_b_ready: got %b want 1", b_req_ready); failures++; end checks++;
        step();
        if (b_rdata !== 32'hBBBB_0000) begin $display("FAIL same_addr_b_rdata: got %h want bbbb0000", b_rdata); failures++; end checks++;
        if (dut.prio !== 1'b1) begin $display("FAIL same_addr_prio: got %b want 1", dut.prio); failures++; end checks++;
        drive_b(0, 0, '0, '0, '0);
        drive_a(1, 0, 10'd6, 32'h0, 4'h0);
        step();
        if (a_rdata !== 32'hBBBB_0000) begin $display("FAIL same_addr_final: got %h want bbbb0000", a_rdata); failures++; end checks++;
        drive_a(0, 0, '0, '0, '0);
        step();
    endtask

    task automatic test_back_to_back();
        drive_a(1, 1, 10'd12, 32'h1234_5678, 4'hF);
        step();
        drive_a(0, 0, '0, '0, '0);
        drive_b(1, 0, 10'd12, 32'h0, 4'h0);
        step();
        if (b_rdata !== 32'h1234_5678) begin $display("FAIL b2b_coherent: got %h want 12345678", b_rdata); failures++; end checks++;
        drive_b(0, 0, '0, '0, '0);
        drive_a(1, 1, 10'd1023, 32'hCAFE_F00D, 4'hF);
        step();
        drive_a(1, 0, 10'd1023, 32'h0, 4'h0);
        step();
        if (a_rsp_valid !== 1'b1 || a_rdata !== 32'hCAFE_F00D) begin
            $display("FAIL top_addr: got %b/%h want 1/cafef00d", a_rsp_valid, a_rdata); failures++;
        end checks++;
        drive_a(1, 1, 10'd5, 32'h0, 4'h0);
        step();
        if (a_rsp_valid !== 1'b1 || a_rdata !== 32'hDEAD_BEEF) begin
            $display("FAIL be0_rsp: got %b/%h want 1/deadbeef", a_rsp_valid, a_rdata); failures++;
        end checks++;
        drive_a(1, 0, 10'd5, 32'h0, 4'h0);
        step();
        if (a_rdata !== 32'hDEAD_BEEF) begin $display("FAIL be0_readback: got %h want deadbeef", a_rdata); failures++; end checks++;
        drive_a(0, 0, '0, '0, '0);
        step();
        if (a_rsp_valid !== 1'b0) begin $display("FAIL b2b_idle: got %b want 0", a_rsp_valid); failures++; end checks++;
    endtask

    task automatic test_reset_blocks_write();
        drive_a(1, 1, 10'd7, 32'hAAAA_AAAA, 4'hF);
        step();
        rst = 1'b1;
        drive_a(1, 1, 10'd7, 32'h5555_5555, 4'hF);
        #1;
        if (a_req_ready !== 1'b0) begin $display("FAIL rstw_ready: got %b want 0", a_req_ready); failures++; end checks++;
        repeat (2) step();
        rst = 1'b0;
        drive_a(0, 0, '0, '0, '0);
        #1;
        if (a_rsp_valid !== 1'b0 || a_rdata !== 32'h0) begin
            $display("FAIL rstw_out: got %b/%h want 0/0", a_rsp_valid, a_rdata); failures++;
        end checks++;
        if (dut.prio !== 1'b0) begin $display("FAIL rstw_prio: got %b want 0", dut.prio); failures++; end checks++;
        drive_a(1, 0, 10'd7, 32'h0, 4'h0);
        step();
        if (a_rdata !== 32'hAAAA_AAAA) begin $display("FAIL rstw_mem: got %h want aaaaaaaa", a_rdata); failures++; end checks++;
        drive_a(0, 0, '0, '0, '0);
        step();
    endtask

    task automatic test_latency3();
        for (int k = 0; k < 4; k++) begin
            drive_ta(1, 1, 10'(k), 32'h10 + 32'(k), 4'hF);
            step();
        end
        drive_ta(0, 0, '0, '0, '0);
        repeat (5) step();
        if (t_a_rsp_valid !== 1'b0) begin $display("FAIL l3_drain: got %b want 0", t_a_rsp_valid); failures++; end checks++;
        for (int k = 0; k < 8; k++) begin
            logic        exp_v;
            logic [31:0] exp_d;
            if (k < 4) drive_ta(1, 0, 10'(k), 32'h0, 4'h0);
            else       drive_ta(0, 0, '0, '0, '0);
            step();
            exp_v = (k >= 2 && k <= 5);
            exp_d = (k < 2) ? 32'h13 : (k <= 5) ? 32'h10 + 32'(k - 2) : 32'h13;
            if (t_a_rsp_valid !== exp_v) begin
                $display("FAIL l3_valid[%0d]: got %b want %b", k, t_a_rsp_valid, exp_v); failures++;
            end checks++;
            if (k >= 2 && t_a_rdata !== exp_d) begin
                $display("FAIL l3_rdata[%0d]: got %h want %h", k, t_a_rdata, exp_d); failures++;
            end
            if (k >= 2) checks++;
        end
    endtask

    task automatic test_reset_flush();
        drive_ta(1, 0, 10'd2, 32'h0, 4'h0);
        drive_tb(1, 0, 10'd6, 32'h0, 4'h0);
        #1;
        if (t_a_req_ready !== 1'b1 || t_b_req_ready !== 1'b0) begin
            $display("FAIL fl_ready: got %b%b want 10", t_a_req_ready, t_b_req_ready); failures++;
        end checks++;
        step();
        if (dut3.prio !== 1'b1) begin $display("FAIL fl_prio_set: got %b want 1", dut3.prio); failures++; end checks++;
        rst = 1'b1;
        #1;
        if (t_a_req_ready !== 1'b0 || t_b_req_ready !== 1'b0) begin
            $display("FAIL fl_rst_ready: got %b%b want 00", t_a_req_ready, t_b_req_ready); failures++;
        end checks++;
        step();
        rst = 1'b0;
        drive_ta(0, 0, '0, '0, '0);
        drive_tb(0, 0, '0, '0, '0);
        #1;
        if (t_a_rdata !== 32'h0) begin $display("FAIL fl_rdata: got %h want 0", t_a_rdata); failures++; end checks++;
        if (dut3.prio !== 1'b0) begin $display("FAIL fl_prio: got %b want 0", dut3.prio); failures++; end checks++;
        for (int k = 0; k < 5; k++) begin
            if (t_a_rsp_valid !== 1'b0 || t_b_rsp_valid !== 1'b0) begin
                $display("FAIL fl_no_rsp[%0d]: got %b%b want 00", k, t_a_rsp_valid, t_b_rsp_valid); failures++;
            end checks++;
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        test_reset();
        test_write_read();
        test_byte_enable();
        test_conflict();
        test_parallel();
        test_back_to_back();
        test_reset_blocks_write();
        test_latency3();
        test_reset_flush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
